// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Contents: loader FSM state type, byte/word/length widths, default
// base address and maximum accepted word count.
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;

    localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned       DEF_MAX_WORDS = 1024;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian word assembler: collects four accepted bytes (LSB first)
// into a 32-bit word.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   byte_en         a payload byte is accepted this cycle
//   byte_in         the payload byte
//   word            assembled word; valid while word_valid is high
//   word_valid      high in the cycle the 4th byte of a word is accepted
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]               cnt;
    // Only the first three bytes need storage; the fourth is taken live.
    logic [WORD_W-BYTE_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            shreg <= '0;
        end else if (byte_en) begin
            cnt   <= cnt + 2'd1;
            shreg <= {byte_in, shreg[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    assign word       = {byte_in, shreg};
    assign word_valid = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader. Receives a length-prefixed, XOR-checksummed
// byte frame, writes each little-endian word to instruction memory and
// keeps the core held until the image is loaded and verified.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_data/in_ready  byte stream handshake
//   imem_we/addr/wdata       registered one-cycle instruction-memory write
//   core_hold                core held in reset while high
//   done / error             sticky frame-accepted / frame-rejected status
//
// state | meaning
// LEN0  | waiting for word-count low byte
// LEN1  | waiting for word-count high byte
// DATA  | receiving payload words
// CSUM  | waiting for checksum byte
// DONE  | image loaded and verified (terminal)
// ERR   | frame rejected (terminal)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned       MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    state_t            state, state_nx;
    logic              accept;
    logic [BYTE_W-1:0] len_lo;
    logic [BYTE_W-1:0] xacc;
    logic [LEN_W-1:0]  len_full;
    logic [LEN_W-1:0]  n_words;
    logic [LEN_W-1:0]  wcnt;
    logic              last_word;
    logic [WORD_W-1:0] asm_word;
    logic              asm_valid;

    assign in_ready  = !rst && (state inside {LEN0, LEN1, DATA, CSUM});
    assign accept    = in_valid && in_ready;
    assign len_full  = {in_data, len_lo};
    assign last_word = ((wcnt + 16'd1) == n_words);

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (accept && (state == DATA)),
        .byte_in    (in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEN0;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LEN0: begin
                if (accept) begin
                    state_nx = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    if (32'(len_full) > MAX_WORDS) begin
                        state_nx = ERR;
                    end else if (len_full == '0) begin
                        state_nx = CSUM;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                // asm_valid already implies a byte was accepted
                if (asm_valid && last_word) begin
                    state_nx = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_nx = (in_data == xacc) ? DONE : ERR;
                end
            end
            default: begin
                state_nx = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo     <= '0;
            n_words    <= '0;
            wcnt       <= '0;
            xacc       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            imem_we <= asm_valid;
            // Checksum covers the length bytes and the payload, not itself
            if (accept && (state inside {LEN0, LEN1, DATA})) begin
                xacc <= xacc ^ in_data;
            end
            if (accept && (state == LEN0)) begin
                len_lo <= in_data;
            end
            if (accept && (state == LEN1)) begin
                n_words <= len_full;
            end
            if (asm_valid) begin
                imem_addr  <= BASE_ADDR + {{(WORD_W-LEN_W-2){1'b0}}, wcnt, 2'b00};
                imem_wdata <= asm_word;
                wcnt       <= wcnt + 16'd1;
            end
        end
    end

    assign done      = !rst && (state == DONE);
    assign error     = !rst && (state == ERR);
    assign core_hold = rst || (state != DONE);

endmodule
